// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, reset defaults, control bundle.
package mips_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CTRL_W     = 7;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [OPCODE_W-1:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // Bit order matches the ID/EX control bundle, MSB first.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_dst;
    logic alu_src;
  } ctrl_t;

  // Main control decode; unknown opcodes decode as a NOP.
  function automatic ctrl_t decode_ctrl(input logic [OPCODE_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      OP_LW:    begin c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ:   begin c.branch = 1'b1; end
      OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/if_id_front_end_if.sv
// ID/EX bundle produced by the fetch/decode front end for the EX/MEM/WB back end.
interface if_id_front_end_if;
  logic [31:0] PCAddResult_out;
  logic [31:0] ReadData1_out;
  logic [31:0] ReadData2_out;
  logic [31:0] signExtend_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
  logic        MemtoReg_out;
  logic        Branch_out;
  logic        MemRead_out;
  logic        MemWrite_out;
  logic        RegDst_out;
  logic        ALUSrc_out;
  logic [5:0]  ALUOp_out;

  modport master (
    output PCAddResult_out, ReadData1_out, ReadData2_out, signExtend_out, rt_out, rd_out,
           RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, RegDst_out,
           ALUSrc_out, ALUOp_out
  );

  modport slave (
    input  PCAddResult_out, ReadData1_out, ReadData2_out, signExtend_out, rt_out, rd_out,
           RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, RegDst_out,
           ALUSrc_out, ALUOp_out
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file: 2 combinational reads, 1 write, WB bypass, r0 hardwired to 0.
module reg_file
  import mips_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [31:0]           rdata1_o,
  output logic [31:0]           rdata2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [31:0]           wdata_i
);

  logic [31:0] rf_q [32];

  // Register write on the rising edge; reset clears every GPR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see a same-cycle WB write so ID never sees a stale value.
  always_comb begin
    rdata1_o = rf_q[raddr1_i];
    rdata2_o = rf_q[raddr2_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/if_id_front_end.sv
// Fetch + decode front end: PC, IF/ID register, register file, control decode, load-use stall.
module if_id_front_end
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [31:0]        Instruction_in,
  output logic [31:0]        PC_out,
  input  logic               PCSrc_in,
  input  logic [31:0]        BranchTarget_in,
  input  logic               RegWrite_WB_in,
  input  logic [4:0]         WriteReg_WB_in,
  input  logic [31:0]        WriteData_WB_in,
  input  logic               MemRead_IDEX_in,
  input  logic [4:0]         rt_IDEX_in,
  output logic               Stall_out,
  if_id_front_end_if.master  idex
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0]           pc_plus4;
  logic [REG_ADDR_W-1:0] rs, rt;
  logic                  stall;
  ctrl_t                 ctrl;

  assign pc_plus4 = pc_q + 32'd4;
  assign rs       = ifid_instr_q[25:21];
  assign rt       = ifid_instr_q[20:16];

  // Load-use hazard; a taken branch overrides the stall since IF/ID is being flushed.
  assign stall = ifid_valid_q && MemRead_IDEX_in && (rt_IDEX_in != '0) &&
                 ((rt_IDEX_in == rs) || (rt_IDEX_in == rt)) && !PCSrc_in;

  // Next-state selection for PC and IF/ID: flush > stall > advance.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    if (PCSrc_in) begin
      pc_d         = BranchTarget_in;
      ifid_instr_d = NOP_INSTR;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d         = pc_plus4;
      ifid_instr_d = Instruction_in;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

  // PC and IF/ID pipeline registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Control decode; a bubble or an invalid IF/ID slot drives all controls to 0.
  always_comb begin
    ctrl = '0;
    if (ifid_valid_q && !stall) ctrl = decode_ctrl(ifid_instr_q[31:26]);
  end

  reg_file u_reg_file (
    .clk_i    (Clk),
    .rst_ni   (Reset_n),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (idex.ReadData1_out),
    .rdata2_o (idex.ReadData2_out),
    .we_i     (RegWrite_WB_in),
    .waddr_i  (WriteReg_WB_in),
    .wdata_i  (WriteData_WB_in)
  );

  assign PC_out               = pc_q;
  assign Stall_out            = stall;
  assign idex.PCAddResult_out = ifid_pc4_q;
  assign idex.signExtend_out  = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
  assign idex.rt_out          = ifid_instr_q[20:16];
  assign idex.rd_out          = ifid_instr_q[15:11];
  assign idex.ALUOp_out       = ifid_instr_q[31:26];
  assign idex.RegWrite_out    = ctrl.reg_write;
  assign idex.MemtoReg_out    = ctrl.mem_to_reg;
  assign idex.Branch_out      = ctrl.branch;
  assign idex.MemRead_out     = ctrl.mem_read;
  assign idex.MemWrite_out    = ctrl.mem_write;
  assign idex.RegDst_out      = ctrl.reg_dst;
  assign idex.ALUSrc_out      = ctrl.alu_src;

endmodule

// File: tb/tb_if_id_front_end.sv
// Scoreboard bench for the fetch/decode front end.
module tb_if_id_front_end;
  import mips_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [31:0] Instruction_in;
  logic [31:0] PC_out;
  logic        PCSrc_in;
  logic [31:0] BranchTarget_in;
  logic        RegWrite_WB_in;
  logic [4:0]  WriteReg_WB_in;
  logic [31:0] WriteData_WB_in;
  logic        MemRead_IDEX_in;
  logic [4:0]  rt_IDEX_in;
  logic        Stall_out;

  if_id_front_end_if idex ();

  if_id_front_end #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .Instruction_in  (Instruction_in),
    .PC_out          (PC_out),
    .PCSrc_in        (PCSrc_in),
    .BranchTarget_in (BranchTarget_in),
    .RegWrite_WB_in  (RegWrite_WB_in),
    .WriteReg_WB_in  (WriteReg_WB_in),
    .WriteData_WB_in (WriteData_WB_in),
    .MemRead_IDEX_in (MemRead_IDEX_in),
    .rt_IDEX_in      (rt_IDEX_in),
    .Stall_out       (Stall_out),
    .idex            (idex)
  );

  always #5 Clk = ~Clk;

  // Control bundle codes, {RegWrite,MemtoReg,Branch,MemRead,MemWrite,RegDst,ALUSrc}
  localparam logic [31:0] C_NONE = 32'h00;
  localparam logic [31:0] C_R    = 32'h42;
  localparam logic [31:0] C_LW   = 32'h69;
  localparam logic [31:0] C_SW   = 32'h05;
  localparam logic [31:0] C_BEQ  = 32'h10;
  localparam logic [31:0] C_ADDI = 32'h41;

  localparam logic [31:0] I_ADDI8  = 32'h2008_0005;  // addi $8,$0,5
  localparam logic [31:0] I_ADD988 = 32'h0108_4820;  // add  $9,$8,$8
  localparam logic [31:0] I_LW     = 32'h8D0A_0004;  // lw   $10,4($8)
  localparam logic [31:0] I_ADD00  = 32'h0000_5820;  // add  $11,$0,$0

  typedef enum int unsigned {S_PC, S_PC4, S_RD1, S_RD2, S_SEXT, S_RT, S_RD, S_CTRL, S_ALUOP, S_STALL} sel_e;
  typedef struct { string tag; sel_e sel; logic [31:0] exp; } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_PC:    return PC_out;
      S_PC4:   return idex.PCAddResult_out;
      S_RD1:   return idex.ReadData1_out;
      S_RD2:   return idex.ReadData2_out;
      S_SEXT:  return idex.signExtend_out;
      S_RT:    return {27'd0, idex.rt_out};
      S_RD:    return {27'd0, idex.rd_out};
      S_CTRL:  return {25'd0, idex.RegWrite_out, idex.MemtoReg_out, idex.Branch_out,
                       idex.MemRead_out, idex.MemWrite_out, idex.RegDst_out, idex.ALUSrc_out};
      S_ALUOP: return {26'd0, idex.ALUOp_out};
      S_STALL: return {31'd0, Stall_out};
      default: return '0;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input sel_e s, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sel = s; x.exp = e;
    sb_q.push_back(x);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t x;
    #2;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check_eq(x.tag, observe(x.sel), x.exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [31:0] tab_instr [4] = '{32'h2108_FFFC, 32'hAD0A_0008, 32'h1109_0002, 32'h0800_0000};
  logic [31:0] tab_ctrl  [4] = '{C_ADDI, C_SW, C_BEQ, C_NONE};
  logic [31:0] tab_sext  [4] = '{32'hFFFF_FFFC, 32'h8, 32'h2, 32'h0};
  logic [31:0] tab_aluop [4] = '{32'h08, 32'h2B, 32'h04, 32'h02};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Instruction_in = I_ADDI8; PCSrc_in = 1'b0; BranchTarget_in = '0;
    RegWrite_WB_in = 1'b0; WriteReg_WB_in = '0; WriteData_WB_in = '0;
    MemRead_IDEX_in = 1'b0; rt_IDEX_in = '0;

    // Reset state
    #1;
    push("rst_pc", S_PC, 32'h0); push("rst_pc4", S_PC4, 32'h0);
    push("rst_ctrl", S_CTRL, C_NONE); push("rst_stall", S_STALL, 32'h0);
    drain();
    tick(); tick();
    push("rst_hold_pc", S_PC, 32'h0); push("rst_hold_ctrl", S_CTRL, C_NONE);
    drain();
    @(negedge Clk); Reset_n = 1'b1;
    push("rel_pc", S_PC, 32'h0);
    drain();

    // First fetch/decode: addi $8,$0,5
    tick();
    push("e1_pc", S_PC, 32'h4); push("e1_pc4", S_PC4, 32'h4); push("e1_ctrl", S_CTRL, C_ADDI);
    push("e1_sext", S_SEXT, 32'h5); push("e1_aluop", S_ALUOP, 32'h08); push("e1_rt", S_RT, 32'h8);
    drain();
    tick();
    push("e2_pc", S_PC, 32'h8); push("e2_pc4", S_PC4, 32'h8);
    drain();

    // WB bypass while decoding add $9,$8,$8
    Instruction_in = I_ADD988;
    tick();
    RegWrite_WB_in = 1'b1; WriteReg_WB_in = 5'd8; WriteData_WB_in = 32'hDEAD_BEEF;
    push("byp_rd1", S_RD1, 32'hDEAD_BEEF); push("byp_rd2", S_RD2, 32'hDEAD_BEEF);
    push("add_ctrl", S_CTRL, C_R); push("add_rd", S_RD, 32'h9); push("add_pc4", S_PC4, 32'hC);
    drain();
    tick();
    RegWrite_WB_in = 1'b0;
    push("stored_rd1", S_RD1, 32'hDEAD_BEEF); push("e4_pc", S_PC, 32'h10);
    drain();

    // Load-use stall on rs=8
    MemRead_IDEX_in = 1'b1; rt_IDEX_in = 5'd8; Instruction_in = I_LW;
    push("stall_on", S_STALL, 32'h1); push("stall_ctrl", S_CTRL, C_NONE); push("stall_pc4", S_PC4, 32'h10);
    drain();
    tick();
    push("stall_pc_hold", S_PC, 32'h10); push("stall_ifid_hold", S_PC4, 32'h10);
    drain();
    MemRead_IDEX_in = 1'b0;
    push("resume_stall", S_STALL, 32'h0); push("resume_ctrl", S_CTRL, C_R); push("resume_rd", S_RD, 32'h9);
    drain();
    MemRead_IDEX_in = 1'b1; rt_IDEX_in = 5'd0;
    push("nostall_rt0", S_STALL, 32'h0);
    drain();
    rt_IDEX_in = 5'd5;
    push("nostall_nomatch", S_STALL, 32'h0);
    drain();
    MemRead_IDEX_in = 1'b0; rt_IDEX_in = 5'd0;
    tick();
    push("lw_pc", S_PC, 32'h14); push("lw_pc4", S_PC4, 32'h14); push("lw_ctrl", S_CTRL, C_LW);
    push("lw_sext", S_SEXT, 32'h4); push("lw_rt", S_RT, 32'hA); push("lw_rd1", S_RD1, 32'hDEAD_BEEF);
    drain();

    // Flush overrides a concurrent stall
    MemRead_IDEX_in = 1'b1; rt_IDEX_in = 5'd8;
    push("pre_flush_stall", S_STALL, 32'h1);
    drain();
    PCSrc_in = 1'b1; BranchTarget_in = 32'h40;
    push("flush_kills_stall", S_STALL, 32'h0);
    drain();
    tick();
    push("flush_pc", S_PC, 32'h40); push("flush_ctrl", S_CTRL, C_NONE); push("flush_stall", S_STALL, 32'h0);
    drain();
    PCSrc_in = 1'b0; MemRead_IDEX_in = 1'b0; rt_IDEX_in = 5'd0;

    // Writes to $0 are ignored and never bypassed
    RegWrite_WB_in = 1'b1; WriteReg_WB_in = 5'd0; WriteData_WB_in = 32'h1234; Instruction_in = I_ADD00;
    push("r0_nobypass", S_RD1, 32'h0);
    drain();
    tick();
    RegWrite_WB_in = 1'b0;
    push("r0_rd1", S_RD1, 32'h0); push("r0_rd2", S_RD2, 32'h0);
    push("r0_pc4", S_PC4, 32'h44); push("r0_ctrl", S_CTRL, C_R);
    drain();

    // Opcode table: addi (negative imm), sw, beq, unknown
    for (int i = 0; i < 4; i++) begin
      Instruction_in = tab_instr[i];
      tick();
      push($sformatf("tab%0d_ctrl", i), S_CTRL, tab_ctrl[i]);
      push($sformatf("tab%0d_sext", i), S_SEXT, tab_sext[i]);
      push($sformatf("tab%0d_aluop", i), S_ALUOP, tab_aluop[i]);
      push($sformatf("tab%0d_pc4", i), S_PC4, 32'h48 + 32'(4 * i));
      drain();
    end

    // PC wrap at the top of the address space
    PCSrc_in = 1'b1; BranchTarget_in = 32'hFFFF_FFFC;
    tick();
    PCSrc_in = 1'b0; Instruction_in = I_ADDI8;
    push("wrap_pre_pc", S_PC, 32'hFFFF_FFFC);
    drain();
    tick();
    push("wrap_pc", S_PC, 32'h0); push("wrap_pc4", S_PC4, 32'h0); push("wrap_ctrl", S_CTRL, C_ADDI);
    drain();
    tick();
    push("post_wrap_pc", S_PC, 32'h4);
    drain();

    // Reset mid-stream
    Reset_n = 1'b0;
    #1;
    push("midrst_pc", S_PC, 32'h0); push("midrst_pc4", S_PC4, 32'h0);
    push("midrst_ctrl", S_CTRL, C_NONE); push("midrst_stall", S_STALL, 32'h0);
    drain();
    @(negedge Clk); Reset_n = 1'b1; Instruction_in = I_ADD988;
    tick();
    push("gpr_cleared", S_RD1, 32'h0); push("after_rst_ctrl", S_CTRL, C_R); push("after_rst_pc", S_PC, 32'h4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
